// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with data-memory control gating, forwarding selects,
// load-use detection and a saturating bubble counter.
module ex_mem_pipe #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [DSIZE-1:0] ex_ALUResult,
    input  logic [DSIZE-1:0] ex_readData1,
    input  logic [ASIZE-1:0] ex_writeReg,
    input  logic             ex_regWrite,
    input  logic             ex_memWriteEnab,
    input  logic             ex_memEnab,
    input  logic             ex_sel_mem2reg,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    output logic [DSIZE-1:0] ALUResult_mem,
    output logic [DSIZE-1:0] readData1,
    output logic             memWriteEnab,
    output logic             memEnab,
    output logic [DSIZE-1:0] ALUResult,
    output logic             sel_mem2reg,
    output logic             mem_regWrite,
    output logic             mem_valid,
    output logic [ASIZE-1:0] mem_writeReg,
    output logic [1:0]       fwdA,
    output logic [1:0]       fwdB,
    output logic             loadUse,
    output logic [15:0]      bubbleCount
);

    logic [DSIZE-1:0] r_alu;
    logic [ASIZE-1:0] r_wreg;
    logic             r_sel;
    logic             r_regwrite;
    logic             r_valid;
    logic [15:0]      r_bubble;

    logic             w_go;
    logic             w_ex_fwd_ok;
    logic             w_mem_fwd_ok;
    logic             w_bubble_slot;

    assign w_go = ex_valid & ~flush & ~stall;

    // Memory side effects fire on the same edge the register captures; reset blocks them.
    assign ALUResult_mem = ex_ALUResult;
    assign readData1     = ex_readData1;
    assign memEnab       = ex_memEnab & w_go & Rst;
    assign memWriteEnab  = ex_memWriteEnab & w_go & Rst;

    assign w_bubble_slot = flush | ~ex_valid;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_alu      <= '0;
            r_wreg     <= '0;
            r_sel      <= 1'b0;
            r_regwrite <= 1'b0;
            r_valid    <= 1'b0;
            r_bubble   <= '0;
        end else if (!stall) begin
            if (flush) begin
                r_sel      <= 1'b0;
                r_regwrite <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_alu      <= ex_ALUResult;
                r_wreg     <= ex_writeReg;
                r_sel      <= ex_sel_mem2reg;
                r_regwrite <= ex_regWrite & ex_valid;
                r_valid    <= ex_valid;
            end
            if (w_bubble_slot && (r_bubble != 16'hFFFF)) begin
                r_bubble <= r_bubble + 16'd1;
            end
        end
    end

    assign ALUResult    = r_alu;
    assign mem_writeReg = r_wreg;
    assign sel_mem2reg  = r_sel;
    assign mem_regWrite = r_regwrite;
    assign mem_valid    = r_valid;
    assign bubbleCount  = r_bubble;

    // A load in EX has no result yet, so it cannot feed the EX bypass path.
    assign w_ex_fwd_ok  = ex_valid & ex_regWrite & ~ex_sel_mem2reg;
    assign w_mem_fwd_ok = r_valid & r_regwrite;

    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (w_ex_fwd_ok && (ex_writeReg == id_rs) && (id_rs != '0)) begin
            fwdA = 2'b01;
        end else if (w_mem_fwd_ok && (r_wreg == id_rs) && (id_rs != '0)) begin
            fwdA = 2'b10;
        end
        if (w_ex_fwd_ok && (ex_writeReg == id_rt) && (id_rt != '0)) begin
            fwdB = 2'b01;
        end else if (w_mem_fwd_ok && (r_wreg == id_rt) && (id_rt != '0)) begin
            fwdB = 2'b10;
        end
    end

    assign loadUse = ex_valid & ex_memEnab & ex_sel_mem2reg & ex_regWrite &
                     (ex_writeReg != '0) &
                     ((ex_writeReg == id_rs) | (ex_writeReg == id_rt));

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have parameter DSIZE, default 16, data/ALU word width.
REQ-002 SHALL have parameter ASIZE, default 3, register-file address width; register 0 reads as zero.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous and active-low.
REQ-005 stall  input  1  hold the pipeline register; no new capture.
REQ-006 flush  input  1  squash the instruction currently in EX.
REQ-007 ex_valid  input  1  EX holds a real instruction.
REQ-008 ex_ALUResult  input  DSIZE  EX ALU output, which is also the memory address.
REQ-009 ex_readData1  input  DSIZE  store data.
REQ-010 ex_writeReg  input  ASIZE  destination register.
REQ-011 ex_regWrite, ex_memWriteEnab, ex_memEnab, ex_sel_mem2reg  input  1 each  EX control bits.
REQ-012 id_rs, id_rt  input  ASIZE  ID-stage source register addresses.
REQ-013 ALUResult_mem, readData1  output  DSIZE  combinational feed to the data memory.
REQ-014 memWriteEnab, memEnab  output  1  combinational, gated data-memory controls.
REQ-015 ALUResult  output  DSIZE  registered ALU result for the write-back mux.
REQ-016 sel_mem2reg, mem_regWrite, mem_valid  output  1  registered controls.
REQ-017 mem_writeReg  output  ASIZE  registered destination register.
REQ-018 fwdA, fwdB  output  2  forwarding selects for rs and rt.
REQ-019 loadUse  output  1  load-use hazard request to the hazard logic.
REQ-020 bubbleCount  output  16  saturating count of squashed or empty slots.

Function
REQ-021 go = ex_valid & ~flush & ~stall SHALL be the internal qualifier for memory-side effects and capture.
REQ-022 ALUResult_mem = ex_ALUResult and readData1 = ex_readData1 SHALL be unconditional combinational pass-throughs.
REQ-023 memEnab = ex_memEnab & go and memWriteEnab = ex_memWriteEnab & go SHALL hold, so the synchronous memory acts on the same edge the pipeline register captures.
REQ-024 On an edge with stall=1, all registered outputs SHALL hold their values and bubbleCount SHALL hold.
REQ-025 On an edge with stall=0 and flush=1, mem_valid, mem_regWrite and sel_mem2reg SHALL clear to 0, while ALUResult and mem_writeReg hold.
REQ-026 On an edge with stall=0 and flush=0, the block SHALL capture ALUResult, mem_writeReg and sel_mem2reg from the ex_ inputs.
REQ-027 On that same capture edge, mem_regWrite SHALL take ex_regWrite & ex_valid and mem_valid SHALL take ex_valid.
REQ-028 Simultaneous stall and flush SHALL resolve as stall; the flush is discarded, and the upstream logic re-asserts it.
REQ-029 Latency SHALL be one cycle from the EX inputs to the registered outputs.
REQ-030 fwdA SHALL be 2'b01 when ex_valid & ex_regWrite & ~ex_sel_mem2reg & (ex_writeReg == id_rs) & (id_rs != 0); this path takes priority.
REQ-031 Otherwise fwdA SHALL be 2'b10 when mem_valid & mem_regWrite & (mem_writeReg == id_rs) & (id_rs != 0).
REQ-032 Otherwise fwdA SHALL be 2'b00; fwdB SHALL follow the same rules using id_rt, and 2'b11 SHALL never be driven.
REQ-033 loadUse SHALL equal ex_valid & ex_memEnab & ex_sel_mem2reg & ex_regWrite & (ex_writeReg != 0) & ((ex_writeReg == id_rs) | (ex_writeReg == id_rt)).
REQ-034 bubbleCount SHALL increment on each edge with stall=0 where (flush | ~ex_valid) holds.
REQ-035 bubbleCount SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-036 Rst=0 SHALL immediately, without a clock edge, clear ALUResult, mem_writeReg, sel_mem2reg, mem_regWrite, mem_valid and bubbleCount to 0.
REQ-037 During reset the combinational outputs SHALL follow their inputs, but memEnab and memWriteEnab SHALL be forced to 0.
REQ-038 Reset asserted mid-stall SHALL discard the held contents; the first edge after Rst deasserts SHALL behave as a normal capture.

Verification
REQ-039 Capture: ex_valid=1, ex_ALUResult=16'h1234, ex_writeReg=3, ex_regWrite=1, stall=flush=0 -> after one edge ALUResult=16'h1234, mem_writeReg=3, mem_regWrite=1, mem_valid=1.
REQ-040 Stall/flush: a stall held for 3 edges -> outputs unchanged and bubbleCount unchanged; then flush=1 for 1 edge -> mem_valid=0, mem_regWrite=0, bubbleCount+1, memEnab=0 during the flush cycle.
REQ-041 Forwarding: EX writes r2 (ALU op) and MEM holds r2, with id_rs=2 and id_rt=2 -> fwdA=fwdB=01; when the EX writer is a load -> fwdA=fwdB=10 and loadUse=1; with id_rs=0 -> fwdA=00.
REQ-042 Store gating: ex_memWriteEnab=1 with stall=1 -> memWriteEnab=0; with stall=0 -> memWriteEnab=1 and ALUResult_mem equals ex_ALUResult.
REQ-043 Saturation: ex_valid=0 for 65540 edges -> bubbleCount=16'hFFFF, with no wrap to 0.
REQ-044 Async reset: drop Rst between edges while mem_valid=1 -> all registered outputs read 0 before the next edge and memEnab=0.
